ex_muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer attached to the EX stage of the 5-stage RV32I pipeline. When EX holds a valid M-extension instruction, this block latches the operands and runs a 32-step shift-add multiply or restoring divide. While it runs, it asserts stall to freeze IF/ID/EX and bubble MEM. It returns a one-cycle result that EX muxes into alu_out_s.

---
 rtl/ex_muldiv_seq_pkg.sv | 37 +++
 rtl/ex_muldiv_seq_if.sv | 26 ++
 rtl/ex_muldiv_seq_dp.sv | 149 ++++++++++++++
 rtl/ex_muldiv_seq.sv | 94 +++++++++
 4 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide sequencer.
// Holds the funct3 operation encoding, FSM state encoding and sign-fixup helper.
package ex_muldiv_seq_pkg;

    localparam int XLEN  = 32;
    localparam int STEPS = XLEN;
    localparam int CNT_W = $clog2(STEPS) + 1;

    // funct7 value that marks an OP-format instruction as M-extension
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v, input logic en);
        return en ? ((~v) + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer handshake bundle.
// master = pipeline EX stage, slave = the sequencer.
interface ex_muldiv_seq_if;
    import ex_muldiv_seq_pkg::*;

    logic            start;
    muldiv_op_t      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            resp_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  stall, busy, resp_valid, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, busy, resp_valid, result
    );

endinterface

// File: rtl/ex_muldiv_seq_dp.sv
// Datapath for the multiply/divide sequencer: operand magnitudes, a shared
// 2*XLEN accumulator stepped one bit per cycle, special divide cases and sign fixup.
module ex_muldiv_seq_dp
    import ex_muldiv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            special,
    output logic [XLEN-1:0] special_res,
    output logic [XLEN-1:0] final_res
);

    muldiv_op_t        op_r;
    logic              neg_r;
    logic [XLEN-1:0]   opb_r;
    logic [2*XLEN-1:0] acc_r;

    logic              sgn_a_s;
    logic              sgn_b_s;
    logic              neg_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              b_zero_s;
    logic              ovf_s;

    // Decode operand signedness, magnitudes and the short-circuit divide results
    always_comb begin
        sgn_a_s     = 1'b0;
        sgn_b_s     = 1'b0;
        neg_s       = 1'b0;
        special     = 1'b0;
        special_res = '0;
        b_zero_s    = (b == '0);
        ovf_s       = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
        case (op)
            OP_MULH, OP_DIV: begin
                sgn_a_s = 1'b1;
                sgn_b_s = 1'b1;
                neg_s   = a[XLEN-1] ^ b[XLEN-1];
            end
            OP_MULHSU: begin
                sgn_a_s = 1'b1;
                neg_s   = a[XLEN-1];
            end
            OP_REM: begin
                sgn_a_s = 1'b1;
                sgn_b_s = 1'b1;
                neg_s   = a[XLEN-1];
            end
            default: begin
                neg_s = 1'b0;
            end
        endcase
        case (op)
            OP_DIV: begin
                if (b_zero_s) begin
                    special     = 1'b1;
                    special_res = {XLEN{1'b1}};
                end else if (ovf_s) begin
                    special     = 1'b1;
                    special_res = {1'b1, {(XLEN-1){1'b0}}};
                end else begin
                    special = 1'b0;
                end
            end
            OP_DIVU: begin
                special     = b_zero_s;
                special_res = {XLEN{1'b1}};
            end
            OP_REM: begin
                if (b_zero_s) begin
                    special     = 1'b1;
                    special_res = a;
                end else if (ovf_s) begin
                    special     = 1'b1;
                    special_res = '0;
                end else begin
                    special = 1'b0;
                end
            end
            OP_REMU: begin
                special     = b_zero_s;
                special_res = a;
            end
            default: begin
                special = 1'b0;
            end
        endcase
        mag_a_s = twos_neg(a, sgn_a_s & a[XLEN-1]);
        mag_b_s = twos_neg(b, sgn_b_s & b[XLEN-1]);
    end

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_diff_s;
    logic [2*XLEN-1:0] acc_nxt_s;
    logic [2*XLEN-1:0] prod_fix_s;

    // One iteration: acc = {product_hi, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opb_r};
        div_diff_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, opb_r};
        if (is_div(op_r)) begin
            if (!div_diff_s[XLEN]) begin
                acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt_s = {acc_r[2*XLEN-2:0], 1'b0};
            end
        end else if (acc_r[0]) begin
            acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end else begin
            acc_nxt_s = {1'b0, acc_r[2*XLEN-1:1]};
        end
        // High-half multiplies negate the full 64-bit product before selecting
        prod_fix_s = neg_r ? ((~acc_nxt_s) + (2*XLEN)'(1)) : acc_nxt_s;
        case (op_r)
            OP_MUL:            final_res = acc_nxt_s[XLEN-1:0];
            OP_MULH, OP_MULHSU: final_res = prod_fix_s[2*XLEN-1:XLEN];
            OP_MULHU:          final_res = acc_nxt_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:   final_res = twos_neg(acc_nxt_s[XLEN-1:0], neg_r);
            OP_REM, OP_REMU:   final_res = twos_neg(acc_nxt_s[2*XLEN-1:XLEN], neg_r);
            default:           final_res = '0;
        endcase
    end

    // Operand capture on issue, accumulator update on each busy cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= OP_MUL;
            neg_r <= 1'b0;
            opb_r <= '0;
            acc_r <= '0;
        end else if (load) begin
            op_r  <= op;
            neg_r <= neg_s;
            opb_r <= mag_b_s;
            acc_r <= {{XLEN{1'b0}}, mag_a_s};
        end else if (step) begin
            acc_r <= acc_nxt_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: IDLE/BUSY/DONE FSM,
// step counter, pipeline stall and one-cycle registered response.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_seq_if.slave    bus
);

    muldiv_state_t   state_r;
    logic [CNT_W-1:0] count_r;
    logic            resp_valid_r;
    logic [XLEN-1:0] result_r;

    logic            load_s;
    logic            step_s;
    logic            special_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN-1:0] final_res_s;

    assign load_s = (state_r == ST_IDLE) && bus.start && !bus.flush;
    assign step_s = (state_r == ST_BUSY) && !bus.flush;

    ex_muldiv_seq_dp u_dp (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .step        (step_s),
        .op          (bus.op),
        .a           (bus.a),
        .b           (bus.b),
        .special     (special_s),
        .special_res (special_res_s),
        .final_res   (final_res_s)
    );

    // Sequencer FSM; result is captured on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            resp_valid_r <= 1'b0;
            result_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_r <= '0;
                    if (load_s && special_s) begin
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        result_r     <= special_res_s;
                    end else if (load_s) begin
                        state_r      <= ST_BUSY;
                        resp_valid_r <= 1'b0;
                    end else begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        count_r <= '0;
                    end else if (count_r == CNT_W'(STEPS - 1)) begin
                        state_r      <= ST_DONE;
                        count_r      <= '0;
                        resp_valid_r <= 1'b1;
                        result_r     <= final_res_s;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    count_r      <= '0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // stall must rise in the issue cycle so EX holds its operands
    assign bus.stall      = !rst && !bus.flush &&
                            (((state_r == ST_IDLE) && bus.start) || (state_r == ST_BUSY));
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.resp_valid = resp_valid_r && !bus.flush;
    assign bus.result     = result_r;

endmodule
